// File: rtl/mem_xfer_pkg.sv
// Shared types for the memory-to-memory transfer engine.
package mem_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        DRAIN,
        DONE,
        ERR
    } xfer_state_t;

    // Address width for a memory of the given depth (at least one bit).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_xfer_if.sv
// Fill, command, status and B read-port signals of the transfer engine.
interface mem_xfer_if
    import mem_xfer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned ADDR_W = addr_w(DEPTH);

    logic [WIDTH-1:0]  dataInA;
    logic              dataInValid;
    logic              dataInReady;
    logic              fillClear;
    logic              aFull;
    logic              start;
    logic [ADDR_W-1:0] srcBase;
    logic [ADDR_W-1:0] dstBase;
    logic [ADDR_W:0]   xferLen;
    logic              reverse;
    logic              busy;
    logic              done;
    logic              err;
    logic [WIDTH-1:0]  checksum;
    logic [ADDR_W-1:0] rdAddrB;
    logic [WIDTH-1:0]  rdDataB;

    modport master (
        output dataInA, dataInValid, fillClear, start, srcBase, dstBase, xferLen, reverse, rdAddrB,
        input  dataInReady, aFull, busy, done, err, checksum, rdDataB
    );

    modport slave (
        input  dataInA, dataInValid, fillClear, start, srcBase, dstBase, xferLen, reverse, rdAddrB,
        output dataInReady, aFull, busy, done, err, checksum, rdDataB
    );

endinterface

// File: rtl/sp_sync_ram.sv
// Synchronous-write RAM with one write and one registered read address.
// A read of the address being written returns the previous contents.
module sp_sync_ram
    import mem_xfer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_xfer_engine.sv
// Fills memory A from a stream and copies a block from A to B, forward or reversed,
// one word per cycle, with a running checksum of the copied words.
module mem_xfer_engine
    import mem_xfer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       Reset,
    mem_xfer_if.slave  bus
);

    localparam int unsigned       ADDR_W   = addr_w(DEPTH);
    localparam int unsigned       LEN_W    = ADDR_W + 1;
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    xfer_state_t       r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_ready;
    logic              r_afull;
    logic [ADDR_W-1:0] r_fill_ptr;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_idx;
    logic              r_rev;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_checksum;

    logic              w_a_we;
    logic              w_b_we;
    logic [ADDR_W-1:0] w_src_addr;
    logic [WIDTH-1:0]  w_a_rdata;

    // r_ready is high exactly in IDLE, so fills are only taken there.
    assign w_a_we     = r_ready && bus.dataInValid && !bus.fillClear && !Reset;
    assign w_b_we     = r_wr_valid && !Reset;
    assign w_src_addr = r_rev ? ADDR_W'(r_src + r_last - r_idx) : ADDR_W'(r_src + r_idx);

    sp_sync_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram_a (
        .clk     (clk),
        .Reset   (Reset),
        .i_we    (w_a_we),
        .i_waddr (r_fill_ptr),
        .i_wdata (bus.dataInA),
        .i_raddr (w_src_addr),
        .o_rdata (w_a_rdata)
    );

    // B is written one cycle behind the A read that produced the word.
    sp_sync_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram_b (
        .clk     (clk),
        .Reset   (Reset),
        .i_we    (w_b_we),
        .i_waddr (r_wr_addr),
        .i_wdata (w_a_rdata),
        .i_raddr (bus.rdAddrB),
        .o_rdata (bus.rdDataB)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ready    <= 1'b1;
            r_afull    <= 1'b0;
            r_fill_ptr <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_last     <= '0;
            r_idx      <= '0;
            r_rev      <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_checksum <= '0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_valid <= 1'b0;
            if (r_wr_valid) begin
                r_checksum <= r_checksum + w_a_rdata;
            end
            case (r_state)
                IDLE: begin
                    if (bus.fillClear) begin
                        r_fill_ptr <= '0;
                        r_afull    <= 1'b0;
                    end else if (w_a_we) begin
                        r_fill_ptr <= r_fill_ptr + ADDR_W'(1);
                        if (r_fill_ptr == PTR_LAST) begin
                            r_afull <= 1'b1;
                        end
                    end
                    if (bus.start) begin
                        r_src      <= bus.srcBase;
                        r_dst      <= bus.dstBase;
                        r_last     <= ADDR_W'(bus.xferLen - LEN_W'(1));
                        r_rev      <= bus.reverse;
                        r_idx      <= '0;
                        r_checksum <= '0;
                        r_ready    <= 1'b0;
                        if (bus.xferLen > LEN_MAX) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end else if (bus.xferLen == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= XFER;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= r_dst + r_idx;
                    r_idx      <= r_idx + ADDR_W'(1);
                    if (r_idx == r_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                DONE, ERR: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.dataInReady = r_ready;
    assign bus.aFull       = r_afull;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.checksum    = r_checksum;

endmodule

// File: tb/tb_mem_xfer_engine.sv
// Bench for mem_xfer_engine: timing-rule model checked every cycle plus literal spot checks.
module tb_mem_xfer_engine;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    mem_xfer_if #(.WIDTH(8), .DEPTH(16)) bus ();

    mem_xfer_engine #(.WIDTH(8), .DEPTH(16)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: memory images, fill state and the most recent accepted command.
    logic [7:0] m_a [16];
    logic [7:0] m_b [16];
    bit         m_bk [16];
    int         m_ptr = 0;
    bit         m_afull = 0;
    int         m_kind = 0;     // 0 none, 1 copy, 2 error
    int         m_S = 0, m_L = 0, m_dst = 0;
    logic [7:0] m_w [16];
    bit         rst_seen = 1'b1;
    logic [3:0] prev_rd = '0;

    always @(posedge clk) rst_seen <= Reset;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    // Outputs after the current edge, from t = cycles since the accept edge.
    function automatic void expect_now(output bit e_busy, output bit e_done, output bit e_err,
                                       output bit e_ready, output logic [7:0] e_sum);
        int t;
        t = cyc - m_S;
        e_busy = 0; e_done = 0; e_err = 0; e_ready = 1; e_sum = '0;
        if (m_kind == 2) begin
            e_err = (t == 0); e_ready = (t >= 1);
        end else if (m_kind == 1 && m_L == 0) begin
            e_done = (t == 0); e_ready = (t >= 1);
        end else if (m_kind == 1) begin
            e_busy  = (t <= m_L);
            e_done  = (t == m_L + 1);
            e_ready = (t >= m_L + 2);
            for (int i = 0; i < m_L; i++)
                if (i + 2 <= t) e_sum = e_sum + m_w[i];
        end
    endfunction

    function automatic bit exp_ready();
        bit b, d, e, r; logic [7:0] s;
        expect_now(b, d, e, r, s);
        return r;
    endfunction

    always @(negedge clk) begin
        bit eb, ed, ee, er; logic [7:0] es; int t;
        if (cyc > 0) begin
            expect_now(eb, ed, ee, er, es);
            chk("busy", 32'(bus.busy), 32'(eb));
            chk("done", 32'(bus.done), 32'(ed));
            chk("err", 32'(bus.err), 32'(ee));
            chk("dataInReady", 32'(bus.dataInReady), 32'(er));
            chk("aFull", 32'(bus.aFull), 32'(m_afull));
            chk("checksum", 32'(bus.checksum), 32'(es));
            if (rst_seen) chk("rdDataB_reset", 32'(bus.rdDataB), 32'(0));
            else if (m_bk[prev_rd]) chk("rdDataB", 32'(bus.rdDataB), 32'(m_b[prev_rd]));
            // Word idx lands in B at edge accept+idx+2.
            if (!rst_seen && m_kind == 1) begin
                t = cyc - m_S - 2;
                if (t >= 0 && t < m_L) begin
                    m_b[(m_dst + t) % 16]  = m_w[t];
                    m_bk[(m_dst + t) % 16] = 1'b1;
                end
            end
        end
        prev_rd = bus.rdAddrB;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_word(input logic [7:0] d);
        bit r;
        bus.dataInA = d; bus.dataInValid = 1'b1;
        r = exp_ready();
        tick();
        bus.dataInValid = 1'b0;
        if (r) begin
            m_a[m_ptr] = d;
            if (m_ptr == 15) m_afull = 1'b1;
            m_ptr = (m_ptr + 1) % 16;
        end
    endtask

    task automatic fill_clear_with_valid();
        bus.fillClear = 1'b1; bus.dataInValid = 1'b1; bus.dataInA = 8'h55;
        tick();
        bus.fillClear = 1'b0; bus.dataInValid = 1'b0;
        m_ptr = 0; m_afull = 1'b0;
    endtask

    task automatic start_xfer(input int src, input int dst, input int len, input bit rev, output int s);
        bit r;
        bus.srcBase = 4'(src); bus.dstBase = 4'(dst); bus.xferLen = 5'(len);
        bus.reverse = rev; bus.start = 1'b1;
        r = exp_ready();
        tick();
        bus.start = 1'b0;
        s = cyc;
        if (r) begin
            m_S = cyc; m_L = len; m_dst = dst; m_kind = (len > 16) ? 2 : 1;
            if (m_kind == 1)
                for (int i = 0; i < len; i++)
                    m_w[i] = m_a[rev ? (src + len - 1 - i) % 16 : (src + i) % 16];
        end
    endtask

    task automatic wait_idle(input int s, output int done_edge, output int busy_cnt);
        done_edge = -1; busy_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) done_edge = cyc - s + 1;
            if (i > 0 && bus.dataInReady) return;
            tick();
        end
        n_cmp++; n_bad++;
        $display("FAIL idle_timeout: engine still busy after 64 cycles (cycle %0d)", cyc);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        if (m_kind == 1)
            for (int i = 0; i < m_L; i++)
                if (m_S + i + 2 >= cyc) m_bk[(m_dst + i) % 16] = 1'b0;
        m_kind = 0; m_ptr = 0; m_afull = 1'b0;
    endtask

    task automatic rd_b(input int addr, input logic [7:0] want, input string name);
        bus.rdAddrB = 4'(addr);
        tick();
        chk(name, 32'(bus.rdDataB), 32'(want));
    endtask

    logic [7:0] fill8 [8];
    int s, s_dummy, de, bc;

    initial begin
        fill8 = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
        bus.dataInA = '0; bus.dataInValid = 1'b0; bus.fillClear = 1'b0; bus.start = 1'b0;
        bus.srcBase = '0; bus.dstBase = '0; bus.xferLen = '0; bus.reverse = 1'b0; bus.rdAddrB = '0;
        for (int i = 0; i < 16; i++) begin m_bk[i] = 1'b0; m_a[i] = '0; m_w[i] = '0; end

        tick(); tick();
        Reset = 1'b0;
        chk("reset_busy", 32'(bus.busy), 32'(0));
        chk("reset_aFull", 32'(bus.aFull), 32'(0));
        chk("reset_checksum", 32'(bus.checksum), 32'(0));
        chk("reset_rdDataB", 32'(bus.rdDataB), 32'(0));
        chk("reset_ready", 32'(bus.dataInReady), 32'(1));

        // Forward copy of eight words to B[4..11].
        for (int i = 0; i < 8; i++) fill_word(fill8[i]);
        chk("t1_aFull_partial", 32'(bus.aFull), 32'(0));
        start_xfer(0, 4, 8, 1'b0, s);
        wait_idle(s, de, bc);
        chk("t1_done_edge", 32'(de), 32'(10));
        chk("t1_busy_cycles", 32'(bc), 32'(9));
        chk("t1_checksum", 32'(bus.checksum), 32'h22);
        for (int i = 0; i < 8; i++) rd_b(4 + i, fill8[i], "t1_B");

        // Reverse copy to B[0..7]; watch B[4] across its overwrite.
        bus.rdAddrB = 4'd4;
        start_xfer(0, 0, 8, 1'b1, s);
        repeat (6) tick();
        chk("t2_rbw_old", 32'(bus.rdDataB), 32'h24);
        tick();
        chk("t2_rbw_new", 32'(bus.rdDataB), 32'h63);
        wait_idle(s, de, bc);
        chk("t2_checksum", 32'(bus.checksum), 32'h22);
        rd_b(0, 8'h12, "t2_B0");
        rd_b(7, 8'h24, "t2_B7");

        // Clear beats a same-cycle fill; full fill; address wrap on both sides.
        fill_clear_with_valid();
        for (int k = 0; k < 16; k++) fill_word(8'(k + 16));
        chk("t3_aFull", 32'(bus.aFull), 32'(1));
        fill_word(8'h99);
        chk("t3_aFull_sticky", 32'(bus.aFull), 32'(1));
        start_xfer(12, 14, 4, 1'b0, s);
        wait_idle(s, de, bc);
        rd_b(14, 8'h1C, "t3_B14");
        rd_b(15, 8'h1D, "t3_B15");
        rd_b(0, 8'h1E, "t3_B0");
        rd_b(1, 8'h1F, "t3_B1");

        // Zero length, then an over-long request.
        start_xfer(0, 0, 0, 1'b0, s);
        wait_idle(s, de, bc);
        chk("t4_len0_done_edge", 32'(de), 32'(1));
        chk("t4_len0_checksum", 32'(bus.checksum), 32'(0));
        start_xfer(0, 0, 17, 1'b0, s);
        chk("t4_err_pulse", 32'(bus.err), 32'(1));
        chk("t4_err_busy", 32'(bus.busy), 32'(0));
        wait_idle(s, de, bc);
        rd_b(0, 8'h1E, "t4_B0_unchanged");

        // Commands and fills while busy are dropped.
        start_xfer(0, 0, 16, 1'b0, s);
        repeat (3) tick();
        start_xfer(5, 9, 2, 1'b0, s_dummy);
        fill_word(8'hEE);
        wait_idle(s, de, bc);
        fill_word(8'h77);
        start_xfer(1, 3, 1, 1'b0, s);
        wait_idle(s, de, bc);
        rd_b(3, 8'h77, "t5_fillptr_kept");

        // Reset in the middle of a transfer, then a clean full copy.
        start_xfer(0, 0, 16, 1'b1, s);
        repeat (5) tick();
        do_reset();
        chk("t5_rst_busy", 32'(bus.busy), 32'(0));
        chk("t5_rst_done", 32'(bus.done), 32'(0));
        chk("t5_rst_aFull", 32'(bus.aFull), 32'(0));
        repeat (20) tick();
        start_xfer(0, 0, 16, 1'b0, s);
        wait_idle(s, de, bc);
        chk("t5_checksum", 32'(bus.checksum), 32'h67);
        rd_b(0, 8'h99, "t5_B0");
        rd_b(1, 8'h77, "t5_B1");
        rd_b(15, 8'h1F, "t5_B15");

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
